// File: rtl/uart_ascii_sender_pkg.sv
// Shared constants, FSM encoding and helpers for the ASCII frame sender.
// Frame: four decimal digits, CR, LF.
package uart_ascii_sender_pkg;

   localparam logic [7:0]  ASCII_0   = 8'h30;
   localparam logic [7:0]  ASCII_SP  = 8'h20;
   localparam logic [7:0]  ASCII_CR  = 8'h0D;
   localparam logic [7:0]  ASCII_LF  = 8'h0A;
   localparam int          FRAME_LEN = 6;
   localparam logic [31:0] MAX_DEC   = 32'd9999;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_FIN
   } state_t;

   function automatic logic [15:0] add3(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // A digit is blanked only when every digit above it is zero.
   function automatic logic [7:0] frame_byte(
      input logic [15:0] bcd,
      input logic [2:0]  idx,
      input logic        lz
   );
      logic [3:0] d;
      logic       blank;
      logic [7:0] r;
      d     = 4'h0;
      blank = 1'b0;
      r     = ASCII_LF;
      case (idx)
         3'd0: begin
            d     = bcd[15:12];
            blank = lz && (bcd[15:12] == 4'h0);
         end
         3'd1: begin
            d     = bcd[11:8];
            blank = lz && (bcd[15:8] == 8'h00);
         end
         3'd2: begin
            d     = bcd[7:4];
            blank = lz && (bcd[15:4] == 12'h000);
         end
         3'd3: d = bcd[3:0];
         default: ;
      endcase
      if (idx <= 3'd3)
         r = blank ? ASCII_SP : (ASCII_0 + {4'h0, d});
      else if (idx == 3'd4)
         r = ASCII_CR;
      return r;
   endfunction

endpackage

// File: rtl/uart_ascii_sender_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock.
// done is high during the cycle whose edge performs the final step.
module bin2bcd_seq
   import uart_ascii_sender_pkg::*;
#(
   parameter int VALUE_W = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [VALUE_W-1:0] bin,
   output logic               done,
   output logic [15:0]        bcd
);

   localparam int CW = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0] shreg;
   logic [CW-1:0]      cnt;
   logic               run;
   logic [15:0]        adj;

   assign adj  = add3(bcd);
   assign done = run && (cnt == CW'(VALUE_W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         bcd   <= '0;
         cnt   <= '0;
         run   <= 1'b0;
      end else if (start) begin
         shreg <= bin;
         bcd   <= '0;
         cnt   <= '0;
         run   <= 1'b1;
      end else if (run) begin
         bcd   <= {adj[14:0], shreg[VALUE_W-1]};
         shreg <= {shreg[VALUE_W-2:0], 1'b0};
         cnt   <= cnt + 1'b1;
         if (done)
            run <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_ascii_sender.sv
// Sends a saturated 0..9999 value as a 6-byte ASCII frame
// through a start/busy UART transmitter interface.
module uart_ascii_sender
   import uart_ascii_sender_pkg::*;
#(
   parameter int LZ_SUPPRESS = 1,
   parameter int VALUE_W     = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [VALUE_W-1:0] value,
   input  logic               tx_busy,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

   state_t             state, state_nx;
   logic [2:0]         byte_idx;
   logic               conv_start, conv_done;
   logic [15:0]        bcd;
   logic [VALUE_W-1:0] sat_value;
   logic               tx_start_nx, busy_nx, done_nx;
   logic [7:0]         tx_data_nx;

   assign conv_start = (state == S_IDLE) && start;

   always_comb begin
      sat_value = value;
      if (32'(value) > MAX_DEC)
         sat_value = VALUE_W'(MAX_DEC);
   end

   bin2bcd_seq #(.VALUE_W(VALUE_W)) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (sat_value),
      .done  (conv_done),
      .bcd   (bcd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         tx_start <= tx_start_nx;
         tx_data  <= tx_data_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         byte_idx <= '0;
      else if (state == S_CONV && conv_done)
         byte_idx <= '0;
      else if (state == S_WAIT_LO && !tx_busy && byte_idx != LAST_IDX)
         byte_idx <= byte_idx + 3'd1;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (start) state_nx = S_CONV;
         S_CONV:    if (conv_done) state_nx = S_ISSUE;
         S_ISSUE:   state_nx = S_WAIT_HI;
         S_WAIT_HI: if (tx_busy) state_nx = S_WAIT_LO;
         S_WAIT_LO: begin
            if (!tx_busy)
               state_nx = (byte_idx == LAST_IDX) ? S_FIN : S_ISSUE;
         end
         S_FIN:     state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Output values for the next edge; tx_data only moves on an issue.
   always_comb begin
      tx_start_nx = (state == S_ISSUE);
      tx_data_nx  = tx_data;
      if (state == S_ISSUE)
         tx_data_nx = frame_byte(bcd, byte_idx, LZ_SUPPRESS != 0);
      busy_nx = (state_nx != S_IDLE);
      done_nx = (state_nx == S_FIN);
   end

endmodule

// File: tb/tb_uart_ascii_sender.sv
// Bench for uart_ascii_sender with a simple uart_tx busy model
// and a printf-based frame reference.
module tb_uart_ascii_sender;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [13:0] value;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic        done;

   logic        hold;
   logic        mbusy;
   int          pend;
   int          hi;
   logic [7:0]  last_byte;
   logic [7:0]  got[$];
   bit          chk_stab;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign tx_busy = hold | mbusy;

   uart_ascii_sender dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .value    (value),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // uart_tx model: busy rises 2 clk after tx_start, high for 20 clk.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mbusy <= 1'b0;
         pend  <= 0;
         hi    <= 0;
      end else if (tx_start) begin
         got.push_back(tx_data);
         last_byte <= tx_data;
         pend      <= 1;
      end else if (pend == 1) begin
         pend  <= 0;
         mbusy <= 1'b1;
         hi    <= 19;
      end else if (mbusy) begin
         if (hi == 0)
            mbusy <= 1'b0;
         else
            hi <= hi - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_stab && tx_busy && !rst)
         chk("tx_data_stable", {24'h0, tx_data}, {24'h0, last_byte});
   end

   function automatic void ref_frame(input int v, output logic [7:0] f[6]);
      string s;
      s = $sformatf("%4d", (v > 9999) ? 9999 : v);
      for (int i = 0; i < 4; i++)
         f[i] = s[i];
      f[4] = 8'h0D;
      f[5] = 8'h0A;
   endfunction

   task automatic run_frame(input int v, input int inject_at,
                            input int rst_at, input bit hold_mode);
      int         n;
      int         ns;
      int         dn;
      bit         injected;
      logic [7:0] f[6];
      got.delete();
      injected = 1'b0;
      @(negedge clk);
      start = 1'b1;
      value = 14'(v);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", {31'h0, busy}, 32'd1);
      n = 0;
      while (!tx_start && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("first_start_latency", n, 32'd15);
      if (hold_mode) begin
         ns = 0;
         repeat (40) begin
            @(negedge clk);
            if (tx_start) ns++;
         end
         chk("no_second_start_while_held", ns, 32'd0);
         hold = 1'b0;
      end
      dn = 0;
      n  = 0;
      while (n < 3000) begin
         @(negedge clk);
         n++;
         if (inject_at >= 0 && !injected && got.size() == inject_at) begin
            injected = 1'b1;
            start    = 1'b1;
            value    = 14'd5555;
            @(negedge clk);
            n++;
            start = 1'b0;
         end
         if (rst_at >= 0 && got.size() == rst_at && tx_busy && hi < 15) begin
            rst = 1'b1;
            #1;
            chk("rst_tx_start", {31'h0, tx_start}, 32'd0);
            chk("rst_tx_data", {24'h0, tx_data}, 32'h00);
            chk("rst_busy", {31'h0, busy}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (done) dn++;
         if (dn > 0 && !busy) break;
      end
      chk("done_in_time", {31'h0, n < 3000}, 32'd1);
      chk("done_pulses", dn, 32'd1);
      chk("busy_low_after", {31'h0, busy}, 32'd0);
      ref_frame(v, f);
      chk("frame_len", got.size(), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < got.size())
            chk($sformatf("byte%0d_v%0d", i, v), {24'h0, got[i]}, {24'h0, f[i]});
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      value    = '0;
      hold     = 1'b0;
      chk_stab = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_tx_start", {31'h0, tx_start}, 32'd0);
      chk("reset_tx_data", {24'h0, tx_data}, 32'h00);
      chk("reset_busy", {31'h0, busy}, 32'd0);
      chk("reset_done", {31'h0, done}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_frame(1234, -1, -1, 1'b0);
      run_frame(7, -1, -1, 1'b0);
      run_frame(0, -1, -1, 1'b0);
      run_frame(12000, -1, -1, 1'b0);
      run_frame(9999, -1, -1, 1'b0);
      run_frame(16383, -1, -1, 1'b0);
      run_frame(1234, 2, -1, 1'b0);
      run_frame(8765, -1, 4, 1'b0);
      repeat (3) @(negedge clk);
      run_frame(42, -1, -1, 1'b0);

      chk_stab = 1'b0;
      hold     = 1'b1;
      repeat (5) @(negedge clk);
      run_frame(3141, -1, -1, 1'b1);
      repeat (30) @(negedge clk);
      chk_stab = 1'b1;

      repeat (6) run_frame(int'($urandom_range(0, 16383)), -1, -1, 1'b0);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
